axi_default_slave: RTL and testbench
====================================

# axi_default_slave

AXI4 default (error) slave that terminates every transaction whose address the address decoder maps to no slave (all-zero `select`). It sits downstream of the decoder, on the interconnect's "no match" port, and completes AW/W/B and AR/R handshakes with DECERR so the master never hangs. The write and read paths are independent, with one outstanding transaction per direction.

## Interface
- `ID_WIDTH`, default 8: AXI ID width on the slave side.
- `DATA_WIDTH`, default 32: R data width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `AWID` in `ID_WIDTH`; `AWLEN` in 8; `AWVALID` in 1; `AWREADY` out 1: write address channel.
- `WLAST` in 1; `WVALID` in 1; `WREADY` out 1: write data channel. Data and strobes are not connected and are discarded.
- `BID` out `ID_WIDTH`; `BRESP` out 2; `BVALID` out 1; `BREADY` in 1: write response channel.
- `ARID` in `ID_WIDTH`; `ARLEN` in 8; `ARVALID` in 1; `ARREADY` out 1: read address channel.
- `RID` out `ID_WIDTH`; `RDATA` out `DATA_WIDTH`; `RRESP` out 2; `RLAST` out 1; `RVALID` out 1; `RREADY` in 1: read data channel.

## Operation
- **Write FSM states:** `W_IDLE`, `W_DATA`, `W_RESP`.
  - `W_IDLE`: `AWREADY`=1. On AW handshake, latch `AWID` and go to `W_DATA`.
  - `W_DATA`: `WREADY`=1. Every beat is accepted and dropped. A handshake with `WLAST`=1 goes to `W_RESP`.
  - Termination is by `WLAST` only. `AWLEN` is latched but not used to end the burst.
  - `W_RESP`: `BVALID`=1, `BID`=latched ID, `BRESP`=DECERR (2'b11). On the B handshake, go to `W_IDLE`.
- **Read FSM states:** `R_IDLE`, `R_DATA`.
  - `R_IDLE`: `ARREADY`=1. On AR handshake, latch `ARID` and load the 8-bit beat counter with `ARLEN`.
  - `R_DATA`: `RVALID`=1, `RDATA`=0, `RRESP`=DECERR, `RID`=latched ID. `RLAST`=1 exactly when the counter is 0.
  - Each R handshake decrements the counter. The handshake with `RLAST`=1 returns the FSM to `R_IDLE`.
  - `ARLEN`=0 gives one beat; `ARLEN`=255 gives 256 beats. The counter never wraps below 0.
- While a VALID is held low by the master, outputs hold their values and the FSM stalls. No timeout.
- Write and read proceed concurrently. Neither path ever waits on the other.
- `WVALID` arriving before any AW is not accepted (`WREADY`=0 outside `W_DATA`).

## Timing
- All READY/VALID outputs and payloads are registered. There are no combinational input-to-output paths.
- **Reset values:**
  - `AWREADY`, `WREADY`, `BVALID`, `ARREADY`, `RVALID`, `RLAST` = 0.
  - `BID`, `RID`, `RDATA` = 0.
  - `BRESP`, `RRESP` = 2'b11.
  - FSMs in `W_IDLE`/`R_IDLE`.
  - `AWREADY` and `ARREADY` rise in the first cycle after `rst` is released.
- **Write sequence:**
  - AW handshake at cycle n: `AWREADY`=0 and `WREADY`=1 at n+1.
  - `WLAST` handshake at m: `WREADY`=0 and `BVALID`=1 at m+1.
  - B handshake at k: `BVALID`=0 and `AWREADY`=1 at k+1.
  - Minimum single-beat write occupies 3 cycles from AW handshake to AW-ready again.
- **Read sequence:**
  - AR handshake at n: `ARREADY`=0 and `RVALID`=1 (first beat) at n+1.
  - With `RREADY` held high, a burst of `ARLEN`+1 beats occupies cycles n+1..n+1+`ARLEN`.
  - `ARREADY`=1 the cycle after the last handshake.
- **Reset mid-transaction:** `rst` returns both FSMs to idle at the next edge and clears all VALIDs. The in-flight transaction is abandoned with no B or R.

## Structure
- Shared `axi_pkg`:
  - Response constants `RESP_OKAY`, `RESP_EXOKAY`, `RESP_SLVERR`, `RESP_DECERR`.
  - `axi_len_t` (8-bit).
  - Write- and read-state enums.
- Sub-module `axi_default_slave_rd`: holds the read FSM and beat counter. The write FSM stays inline in the top.

## Test plan
- After `rst`, `AWVALID`=1, `AWID`=0x5A, `AWLEN`=0, then one W beat with `WLAST`, `BREADY`=1 -> `BVALID` two cycles after AW handshake with `BID`=0x5A, `BRESP`=2'b11; `AWREADY`=1 the following cycle.
- AR with `ARID`=0x33, `ARLEN`=3, `RREADY`=1 -> 4 beats on consecutive cycles, `RDATA`=0, `RRESP`=2'b11, `RID`=0x33, `RLAST` only on beat 4.
- Same read with `RREADY` toggling 1/0 -> beat count stays 4, outputs stable while stalled, `RLAST` on 4th accepted beat only.
- `ARLEN`=255 -> exactly 256 beats and a single `RLAST`.
- Concurrent 4-beat write and 2-beat read issued in the same cycle -> both complete independently with DECERR and correct IDs. Asserting `WVALID` before AW -> `WREADY` stays 0.
- `rst` asserted mid-read (after beat 2 of 4) -> `RVALID`=0 next cycle, `ARREADY`=1 the cycle after `rst` falls, and a new AR completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, burst length type and the
// default-slave FSM state encodings.
package axi_pkg;
  typedef logic [1:0] axi_resp_t;
  typedef logic [7:0] axi_len_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;
endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 subset seen by the default slave; write data/strobes are omitted
// because the slave discards them.
interface axi_default_slave_if #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
);
  import axi_pkg::*;

  logic [ID_WIDTH-1:0]   AWID;
  axi_len_t              AWLEN;
  logic                  AWVALID, AWREADY;
  logic                  WLAST, WVALID, WREADY;
  logic [ID_WIDTH-1:0]   BID;
  axi_resp_t             BRESP;
  logic                  BVALID, BREADY;
  logic [ID_WIDTH-1:0]   ARID;
  axi_len_t              ARLEN;
  logic                  ARVALID, ARREADY;
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  axi_resp_t             RRESP;
  logic                  RLAST, RVALID, RREADY;

  modport master (
    output AWID, AWLEN, AWVALID, WLAST, WVALID, BREADY, ARID, ARLEN, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  AWID, AWLEN, AWVALID, WLAST, WVALID, BREADY, ARID, ARLEN, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_default_slave_rd.sv
// Read half of the default slave: accepts one AR, then returns ARLEN+1
// zero-data DECERR beats with RLAST on the final one.
module axi_default_slave_rd
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid,
  input  axi_len_t            arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  rd_state_e           state_q, state_d;
  axi_len_t            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                ar_hs, r_hs;

  assign ar_hs = arvalid & arready_q;
  assign r_hs  = rvalid_q & rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      rid_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rid_q     <= rid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE:  if (ar_hs) state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they change with the FSM.
  always_comb begin
    cnt_d = cnt_q;
    rid_d = rid_q;
    if (ar_hs) begin
      cnt_d = arlen;
      rid_d = arid;
    end else if (r_hs && cnt_q != '0) begin
      cnt_d = cnt_q - 8'd1;
    end
    arready_d = (state_d == R_IDLE);
    rvalid_d  = (state_d == R_DATA);
    rlast_d   = (state_d == R_DATA) && (cnt_d == '0);
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave on the decoder's no-match port: completes every
// write and read with DECERR. Write FSM inline, read FSM in a sub-module.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_default_slave_if.slave bus
);
  wr_state_e           w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  axi_len_t            awlen_q, awlen_d;
  logic                aw_hs, w_hs, b_hs;

  assign aw_hs = bus.AWVALID & awready_q;
  assign w_hs  = bus.WVALID & wready_q;
  assign b_hs  = bus.BREADY & bvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      awlen_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      awlen_q   <= awlen_d;
    end
  end

  // Burst ends on WLAST alone; the latched AWLEN is kept for visibility only.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && bus.WLAST) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = aw_hs ? bus.AWID  : bid_q;
    awlen_d   = aw_hs ? bus.AWLEN : awlen_q;
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = RESP_DECERR;
  assign bus.RDATA   = '0;
  assign bus.RRESP   = RESP_DECERR;

  axi_default_slave_rd #(.ID_WIDTH(ID_WIDTH)) u_rd (
    .clk     (clk),
    .rst     (rst),
    .arid    (bus.ARID),
    .arlen   (bus.ARLEN),
    .arvalid (bus.ARVALID),
    .arready (bus.ARREADY),
    .rid     (bus.RID),
    .rlast   (bus.RLAST),
    .rvalid  (bus.RVALID),
    .rready  (bus.RREADY)
  );
endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_default_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_default_slave_if #(.ID_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_default_slave #(.ID_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Model: write phase 0/1/2 = waiting AW / taking data / responding;
  // reads tracked as beats still owed. Nothing is ready until one clean edge.
  bit         alive  = 1'b0;
  int         w_ph   = 0;
  int         r_left = 0;
  logic [7:0] m_bid  = '0;
  logic [7:0] m_rid  = '0;

  always @(posedge clk) begin
    if (rst) begin
      alive = 1'b0; w_ph = 0; r_left = 0; m_bid = '0; m_rid = '0;
    end else begin
      case (w_ph)
        0: if (alive && bus.AWVALID) begin m_bid = bus.AWID; w_ph = 1; end
        1: if (bus.WVALID && bus.WLAST) w_ph = 2;
        2: if (bus.BREADY) w_ph = 0;
        default: w_ph = 0;
      endcase
      if (r_left == 0) begin
        if (alive && bus.ARVALID) begin r_left = int'(bus.ARLEN) + 1; m_rid = bus.ARID; end
      end else if (bus.RREADY) begin
        r_left--;
      end
      alive = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("awready", bus.AWREADY, alive && w_ph == 0);
    chk("wready",  bus.WREADY,  w_ph == 1);
    chk("bvalid",  bus.BVALID,  w_ph == 2);
    chk("bid",     bus.BID,     m_bid);
    chk("bresp",   bus.BRESP,   2'b11);
    chk("arready", bus.ARREADY, alive && r_left == 0);
    chk("rvalid",  bus.RVALID,  r_left > 0);
    chk("rlast",   bus.RLAST,   r_left == 1);
    chk("rid",     bus.RID,     m_rid);
    chk("rdata",   bus.RDATA,   32'h0);
    chk("rresp",   bus.RRESP,   2'b11);
  end

  // Handshake monitor for the directed literal checks.
  int         r_beats = 0, rlast_cnt = 0, rlast_idx = 0, b_cnt = 0;
  logic [7:0] b_id_seen = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.RVALID && bus.RREADY) begin
        r_beats++;
        if (bus.RLAST) begin rlast_cnt++; rlast_idx = r_beats; end
      end
      if (bus.BVALID && bus.BREADY) begin b_cnt++; b_id_seen = bus.BID; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [7:0] len, input bit toggle,
                         input int exp_beats, input string tag);
    int n;
    r_beats = 0; rlast_cnt = 0; rlast_idx = 0;
    bus.ARVALID = 1'b1; bus.ARID = id; bus.ARLEN = len; bus.RREADY = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.ARREADY && n < 2000) begin
      if (toggle) bus.RREADY = ~bus.RREADY;
      tick();
      n++;
    end
    bus.RREADY = 1'b1;
    chk({tag, "_done"}, bus.ARREADY, 1'b1);
    chk({tag, "_beats"}, r_beats, exp_beats);
    chk({tag, "_rlast_cnt"}, rlast_cnt, 1);
    chk({tag, "_rlast_idx"}, rlast_idx, exp_beats);
    if (!toggle) chk({tag, "_cycles"}, n, exp_beats);
  endtask

  initial begin
    int n;
    bus.AWID = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
    bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    repeat (3) tick();
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    chk("rst_rresp", bus.RRESP, 2'b11);
    rst = 1'b0;
    tick();
    chk("awready_after_rst", bus.AWREADY, 1'b1);
    chk("arready_after_rst", bus.ARREADY, 1'b1);

    // Single-beat write
    bus.AWVALID = 1'b1; bus.AWID = 8'h5A; bus.AWLEN = 8'd0; bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("wr1_awready_low", bus.AWREADY, 1'b0);
    chk("wr1_wready", bus.WREADY, 1'b1);
    bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    tick();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    chk("wr1_bvalid", bus.BVALID, 1'b1);
    chk("wr1_bid", bus.BID, 8'h5A);
    chk("wr1_bresp", bus.BRESP, 2'b11);
    chk("wr1_wready_low", bus.WREADY, 1'b0);
    tick();
    chk("wr1_bvalid_low", bus.BVALID, 1'b0);
    chk("wr1_awready_back", bus.AWREADY, 1'b1);

    do_read(8'h33, 8'd3, 1'b0, 4, "rd4");
    do_read(8'h34, 8'd3, 1'b1, 4, "rd4_stall");
    do_read(8'h35, 8'd255, 1'b0, 256, "rd256");

    // W before any AW must be refused
    bus.WVALID = 1'b1; bus.WLAST = 1'b0;
    repeat (3) begin
      tick();
      chk("early_w_wready", bus.WREADY, 1'b0);
    end

    // Concurrent 4-beat write and 2-beat read
    b_cnt = 0; r_beats = 0;
    bus.AWVALID = 1'b1; bus.AWID = 8'h11; bus.AWLEN = 8'd3;
    bus.ARVALID = 1'b1; bus.ARID = 8'h22; bus.ARLEN = 8'd1;
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.WLAST = (i == 3);
      tick();
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n = 0;
    while (b_cnt == 0 && n < 20) begin tick(); n++; end
    chk("conc_b_cnt", b_cnt, 1);
    chk("conc_bid", b_id_seen, 8'h11);
    chk("conc_r_beats", r_beats, 2);
    chk("conc_awready", bus.AWREADY, 1'b1);

    // Reset in the middle of a 4-beat read
    r_beats = 0;
    bus.ARVALID = 1'b1; bus.ARID = 8'h44; bus.ARLEN = 8'd3; bus.RREADY = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    tick();
    tick();
    chk("mid_rst_beats_before", r_beats, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", bus.RVALID, 1'b0);
    chk("mid_rst_arready", bus.ARREADY, 1'b0);
    chk("mid_rst_beats_after", r_beats, 2);
    rst = 1'b0;
    tick();
    chk("post_rst_arready", bus.ARREADY, 1'b1);
    do_read(8'h66, 8'd0, 1'b0, 1, "post_rst");
    chk("post_rst_rid", bus.RID, 8'h66);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
